// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and state encoding for the fetch stage
//
// Purpose : common definitions imported by the fetch interface, the next-PC
//           helper and the fetch stage top.
// Contents: ADDR_WIDTH / INST_WIDTH, ZERO_WORD bubble value, reset defaults,
//           the 2-bit fetch state type and a wrapping PC increment helper.
package if_fetch_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] ZERO_WORD        = '0;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int                    PC_STEP_DEFAULT  = 4;

    // FETCH: request outstanding, its result will be kept.
    // KILL : request outstanding, its result is stale and will be dropped.
    // IDLE : no request outstanding.
    typedef enum logic [1:0] {
        IF_ST_FETCH = 2'd0,
        IF_ST_KILL  = 2'd1,
        IF_ST_IDLE  = 2'd2
    } if_state_e;

    // Sequential PC advance; wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc,
                                                     input logic [ADDR_WIDTH-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - single-outstanding req/ack instruction memory port
//
// Purpose : groups the instruction-memory handshake of the fetch stage.
// Signals : req   - fetch request, held until ack
//           addr  - fetch address, stable while req
//           ack   - one-cycle response strobe
//           rdata - instruction word, valid with ack
// Modports: master (fetch stage side), slave (memory side).
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [INST_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/if_fetch_pc_next.sv
// rtl/if_fetch_pc_next.sv - next-PC selection for the fetch stage
//
// Purpose: chooses the PC to load at the next edge.
// Ports  : pc         in  current PC
//          jmp_flag   in  redirect request (highest priority)
//          jmp_target in  redirect PC
//          adv        in  accepted fetch result, step to the next sequential PC
//          pc_nxt     out PC for the next edge
module if_fetch_pc_next
    import if_fetch_pkg::*;
#(
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  jmp_flag,
    input  logic [ADDR_WIDTH-1:0] jmp_target,
    input  logic                  adv,
    output logic [ADDR_WIDTH-1:0] pc_nxt
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    always_comb begin
        pc_nxt = pc;
        if (jmp_flag) begin
            pc_nxt = jmp_target;
        end else if (adv) begin
            pc_nxt = pc_inc(pc, STEP);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with single-outstanding memory port
//
// Purpose: owns the PC, issues one fetch at a time to instruction memory,
//          presents {if_pc, if_inst} to IF/ID and applies EX redirects,
//          discarding any fetch that was in flight when the redirect arrived.
// Ports  : clk        in  clock, rising edge
//          rst_n      in  asynchronous active-low reset
//          stall      in  [0]=PC hold (blocks new issue), [1]=IF/ID hold
//          jmp_flag   in  redirect pulse
//          jmp_target in  redirect PC
//          mem        if  master side of the instruction memory port
//          if_pc      out PC of presented instruction, ZERO_WORD when bubble
//          if_inst    out presented instruction, ZERO_WORD when bubble
//          stall_req  out high while no fresh instruction is held
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                    PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            stall,
    input  logic                  jmp_flag,
    input  logic [ADDR_WIDTH-1:0] jmp_target,
    if_fetch_if.master            mem,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  stall_req
);

    if_state_e             state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic                  out_valid;

    logic consume;
    logic slot_free;
    logic take;
    logic unused_stall;

    // Upper stall bits belong to later stages.
    assign unused_stall = ^stall[5:2];

    assign consume   = out_valid && !stall[1];
    // The slot can accept a new instruction once the current one is gone or
    // leaves at this edge; this also lets IDLE issue after a consume that
    // happened while stall[0] was holding the PC.
    assign slot_free = !out_valid || !stall[1];
    assign take      = (state == IF_ST_FETCH) && mem.ack && !jmp_flag;

    if_fetch_pc_next #(
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .pc         (pc),
        .jmp_flag   (jmp_flag),
        .jmp_target (jmp_target),
        .adv        (take),
        .pc_nxt     (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IF_ST_FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            if_pc     <= ZERO_WORD;
            if_inst   <= ZERO_WORD;
        end else begin
            pc <= pc_nxt;
            if (jmp_flag) begin
                // Flush wins over everything, including stalls and a coincident ack.
                out_valid <= 1'b0;
                if_pc     <= ZERO_WORD;
                if_inst   <= ZERO_WORD;
                case (state)
                    IF_ST_FETCH: state <= mem.ack ? IF_ST_FETCH : IF_ST_KILL;
                    IF_ST_KILL:  state <= mem.ack ? IF_ST_FETCH : IF_ST_KILL;
                    default:     state <= IF_ST_FETCH;
                endcase
            end else if (take) begin
                if_pc     <= pc;
                if_inst   <= mem.rdata;
                out_valid <= 1'b1;
                state     <= IF_ST_IDLE;
            end else begin
                if (consume) begin
                    out_valid <= 1'b0;
                    if_pc     <= ZERO_WORD;
                    if_inst   <= ZERO_WORD;
                end
                case (state)
                    IF_ST_KILL: begin
                        // Stale data is dropped; the PC already holds the redirect.
                        if (mem.ack) begin
                            state <= IF_ST_FETCH;
                        end
                    end
                    IF_ST_IDLE: begin
                        // An ack here is a protocol error and is ignored.
                        if (slot_free && !stall[0]) begin
                            state <= IF_ST_FETCH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem.req   = (state != IF_ST_IDLE);
    assign mem.addr  = pc;
    assign stall_req = ~out_valid;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for the fetch stage
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stall_req;

    if_fetch_if mem ();

    if_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .jmp_flag   (jmp_flag),
        .jmp_target (jmp_target),
        .mem        (mem),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .stall_req  (stall_req)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int n_present = 0;
    int fixed_lat = 1;

    logic [31:0] exp_q[$];
    logic [31:0] jmp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_1E97;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory: latches the address when it first sees a request, answers after
    // the chosen latency with a word derived from that address.
    initial begin : memory
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        mem.ack = 1'b0; mem.rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mem.ack = 1'b0; pend = 1'b0;
            end else if (mem.ack) begin
                mem.ack = 1'b0; mem.rdata = $urandom; pend = 1'b0;
                if (mem.req) begin
                    pend = 1'b1; paddr = mem.addr;
                    cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem.ack = 1'b1; mem.rdata = mem_word(paddr);
                end
            end else if (mem.req) begin
                pend = 1'b1; paddr = mem.addr;
                cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            end
        end
    end

    // Monitor: each newly presented instruction must be the next expected PC
    // of the program stream with its memory word; redirects restart the stream.
    initial begin : monitor
        logic [31:0] e;
        logic [31:0] hp;
        logic [31:0] hi;
        logic        valid;
        logic        prev_hold;
        prev_hold = 1'b0; hp = '0; hi = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); jmp_q.delete();
                exp_q.push_back(RESET_PC_DEFAULT);
                prev_hold = 1'b0;
            end else begin
                valid = !stall_req;
                if (valid) begin
                    chk("req_low_while_presenting", {31'd0, mem.req}, 32'd0);
                    if (prev_hold) begin
                        chk("hold_pc", if_pc, hp);
                        chk("hold_inst", if_inst, hi);
                    end else if (exp_q.size() != 1) begin
                        chk("scoreboard_depth", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("present_pc", if_pc, e);
                        chk("present_inst", if_inst, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                        n_present++;
                    end
                end else begin
                    chk("bubble_zero", if_pc | if_inst, 32'd0);
                end
                hp = if_pc; hi = if_inst;
                prev_hold = valid && stall[1] && !jmp_flag;
                if (jmp_flag) begin
                    exp_q.delete();
                    if (jmp_q.size() > 0) exp_q.push_back(jmp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            step(); n++;
        end while (stall_req && n < 60);
        chk({tag, "_timeout"}, {31'd0, stall_req}, 32'd0);
    endtask

    task automatic jump(input logic [31:0] t);
        jmp_flag = 1'b1; jmp_target = t; jmp_q.push_back(t);
        step();
        jmp_flag = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_req", {31'd0, mem.req}, 32'd1);
        chk("rst_addr", mem.addr, RESET_PC_DEFAULT);
        chk("rst_stall_req", {31'd0, stall_req}, 32'd1);
        chk("rst_out", if_pc | if_inst, 32'd0);
        step();
    endtask

    initial begin : stim
        logic [31:0] p;
        logic [31:0] s;
        logic [31:0] addrs[$];
        logic        prev_req;
        int          lows;
        int          n;
        int          base;

        rst_n = 1'b0; stall = '0; jmp_flag = 1'b0; jmp_target = '0;

        // Reset release and back-to-back throughput with latency 1.
        fixed_lat = 1;
        release_reset();
        wait_valid("first");
        chk("first_pc", if_pc, 32'h0);
        lows = 1; prev_req = mem.req;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!stall_req) lows++;
            if (mem.req && !prev_req) addrs.push_back(mem.addr);
            prev_req = mem.req;
        end
        chk("tput_valid_cycles", 32'(lows), 32'd3);
        chk("tput_issue_count", 32'(addrs.size()), 32'd3);
        for (int i = 0; i < addrs.size() && i < 3; i++)
            chk("tput_addr", addrs[i], 32'(4 * (i + 1)));

        // IF/ID hold for 5 cycles, then resume at the next PC.
        fixed_lat = 2;
        stall = 6'b000010;
        wait_valid("hold");
        p = if_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_stable_pc", if_pc, p);
            chk("hold_no_req", {31'd0, mem.req}, 32'd0);
        end
        stall = '0;
        step();
        chk("resume_req", {31'd0, mem.req}, 32'd1);
        chk("resume_addr", mem.addr, p + 32'd4);

        // PC hold after the slot has been consumed keeps the stage idle.
        stall = 6'b000010;
        wait_valid("pchold");
        p = if_pc;
        stall = 6'b000001;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("pchold_no_req", {31'd0, mem.req}, 32'd0);
            chk("pchold_stall_req", {31'd0, stall_req}, 32'd1);
            step();
        end
        stall = '0;
        step();
        chk("pchold_release_req", {31'd0, mem.req}, 32'd1);
        chk("pchold_release_addr", mem.addr, p + 32'd4);

        // Redirect while a fetch is in flight.
        fixed_lat = 3;
        stall = 6'b000010;
        wait_valid("redir_setup");
        jump(32'h8);
        stall = '0;
        chk("redir_req8", {31'd0, mem.req}, 32'd1);
        chk("redir_addr8", mem.addr, 32'h8);
        chk("redir_flush", if_pc | if_inst, 32'd0);
        step();
        jump(32'h100);
        chk("redir_addr100", mem.addr, 32'h100);
        wait_valid("redir");
        chk("redir_pc", if_pc, 32'h100);
        chk("redir_inst", if_inst, mem_word(32'h100));

        // Redirect in the same cycle as the ack.
        stall = 6'b000010;
        wait_valid("coinc_setup");
        jump(32'hC);
        stall = '0;
        n = 0;
        while (!mem.ack && n < 20) begin step(); n++; end
        chk("coinc_ack_seen", {31'd0, mem.ack}, 32'd1);
        chk("coinc_ack_addr", mem.addr, 32'hC);
        jump(32'h40);
        chk("coinc_addr", mem.addr, 32'h40);
        chk("coinc_bubble", {31'd0, stall_req}, 32'd1);
        wait_valid("coinc");
        chk("coinc_pc", if_pc, 32'h40);

        // PC wrap.
        stall = 6'b000010;
        wait_valid("wrap_setup");
        jump(32'hFFFF_FFFC);
        stall = '0;
        wait_valid("wrap_top");
        chk("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        wait_valid("wrap_zero");
        chk("wrap_zero_pc", if_pc, 32'h0);

        // Async reset while a request is outstanding.
        n = 0;
        while (!(mem.req && mem.addr != 32'h0) && n < 20) begin step(); n++; end
        chk("areset_setup", {31'd0, mem.req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_out", if_pc | if_inst, 32'd0);
        chk("areset_addr", mem.addr, RESET_PC_DEFAULT);
        chk("areset_stall_req", {31'd0, stall_req}, 32'd1);
        release_reset();
        wait_valid("areset");
        chk("areset_restart_pc", if_pc, 32'h0);

        // Randomized stalls, latencies and redirects.
        fixed_lat = 0;
        base = n_present;
        for (int c = 0; c < 3000; c++) begin
            s = $urandom;
            s[1] = ($urandom_range(0, 3) == 0);
            s[0] = ($urandom_range(0, 4) == 0);
            stall = s[5:0];
            if ($urandom_range(0, 19) == 0) begin
                p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                 : ($urandom & 32'hFFFF_FFFC);
                jump(p);
            end else begin
                step();
            end
        end
        stall = '0;
        wait_valid("final");
        chk("random_progress", {31'd0, (n_present - base) >= 150}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
